// File: rtl/fb_pkg.sv
// fb_pkg: shared types and defaults for the frame-buffer port arbiter.
//   FB_ADDR_W / FB_DATA_W : default word address and pixel widths (320x240, RGB444)
//   grant_t               : per-cycle owner of the single RAM port
//   pixel_t               : one RGB444 pixel
package fb_pkg;

   localparam int FB_ADDR_W = 17;
   localparam int FB_DATA_W = 12;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } grant_t;

   typedef logic [FB_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO buffering camera writes as {addr, data} words.
//   i_clk, i_rst     : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_din    : push request and entry; ignored while full
//   i_pop, o_dout    : pop request and current head entry; ignored while empty
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored entries (0..DEPTH)
module fb_wr_fifo #(
   parameter int W     = 29,
   parameter int DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [W-1:0]           i_din,
   input  logic                   i_pop,
   output logic [W-1:0]           o_dout,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign o_full  = (o_count == (PW+1)'(DEPTH));
   assign o_empty = (o_count == '0);
   // Full is judged on the start-of-cycle count, so a pop cannot make room
   // for a push in the same cycle.
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;
   assign o_dout  = mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop_ok)
            o_count <= o_count + (PW+1)'(1);
         else if (pop_ok && !push_ok)
            o_count <= o_count - (PW+1)'(1);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= i_din;
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port frame-buffer RAM between display
// reads (always win) and camera writes (buffered, drained into idle cycles).
//   i_clk, i_rst                   : clock, synchronous active-high reset
//   i_rd_req, i_rd_addr            : display read, one pixel per cycle
//   o_rd_valid, o_rd_data          : read return, RAM_LAT+2 cycles after request
//   i_wr_valid, i_wr_addr, i_wr_data : camera pixel (never stalled)
//   o_wr_ready                     : FIFO not full, advisory
//   o_mem_en/we/addr/wdata         : registered RAM command
//   i_mem_rdata                    : RAM read data, RAM_LAT after command
//   i_clr_stat                     : clears overflow statistics
//   o_overflow, o_drop_cnt         : sticky drop flag, saturating drop count
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FIFO_DEPTH = 16,
   parameter int RAM_LAT    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_clr_stat,
   output logic              o_overflow,
   output logic [15:0]       o_drop_cnt
);

   // vld_pipe[0] lines up with the RAM command, vld_pipe[RAM_LAT] with
   // i_mem_rdata, vld_pipe[STAGES] with o_rd_valid.
   localparam int STAGES = RAM_LAT + 1;
   localparam int EW     = ADDR_W + DATA_W;
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;

   grant_t            grant;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [EW-1:0]     fifo_head;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              drop;
   logic [STAGES:0]   vld_pipe;

   assign {head_addr, head_data} = fifo_head;

   always_comb begin
      grant = GNT_NONE;
      if (i_rd_req)         grant = GNT_RD;
      else if (!fifo_empty) grant = GNT_WR;
   end

   fb_wr_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_wr_valid),
      .i_din   ({i_wr_addr, i_wr_data}),
      .i_pop   (grant == GNT_WR),
      .o_dout  (fifo_head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign drop       = i_wr_valid && fifo_full;
   assign o_wr_ready = !i_rst && (fifo_count != CW'(FIFO_DEPTH));

   // Command register; address and write data hold when idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         case (grant)
            GNT_RD: begin
               o_mem_en   <= 1'b1;
               o_mem_we   <= 1'b0;
               o_mem_addr <= i_rd_addr;
            end
            GNT_WR: begin
               o_mem_en    <= 1'b1;
               o_mem_we    <= 1'b1;
               o_mem_addr  <= head_addr;
               o_mem_wdata <= head_data;
            end
            default: begin
               o_mem_en <= 1'b0;
               o_mem_we <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_pipe  <= '0;
         o_rd_data <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], grant == GNT_RD};
         if (vld_pipe[RAM_LAT]) o_rd_data <= i_mem_rdata;
      end
   end

   assign o_rd_valid = vld_pipe[STAGES];

   // A drop in the same cycle as a clear counts as the first event after it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end else if (drop) begin
         o_overflow <= 1'b1;
         if (i_clr_stat)
            o_drop_cnt <= 16'd1;
         else if (o_drop_cnt != 16'hFFFF)
            o_drop_cnt <= o_drop_cnt + 16'd1;
      end else if (i_clr_stat) begin
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed stimulus against a queue-based model of the
// arbiter, compared every cycle, plus literal checks from hand calculation.
module tb_fb_port_arbiter;
   import fb_pkg::*;

   localparam int AW    = 17;
   localparam int DW    = 12;
   localparam int DEPTH = 16;
   localparam int LAT   = 1;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_rd_req;
   logic [AW-1:0] i_rd_addr;
   logic          o_rd_valid;
   logic [DW-1:0] o_rd_data;
   logic          i_wr_valid;
   logic [AW-1:0] i_wr_addr;
   logic [DW-1:0] i_wr_data;
   logic          o_wr_ready;
   logic          o_mem_en;
   logic          o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [DW-1:0] i_mem_rdata = '0;
   logic          i_clr_stat;
   logic          o_overflow;
   logic [15:0]   o_drop_cnt;

   always #5 i_clk = ~i_clk;

   fb_port_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .FIFO_DEPTH (DEPTH), .RAM_LAT (LAT)
   ) dut (
      .i_clk (i_clk), .i_rst (i_rst),
      .i_rd_req (i_rd_req), .i_rd_addr (i_rd_addr),
      .o_rd_valid (o_rd_valid), .o_rd_data (o_rd_data),
      .i_wr_valid (i_wr_valid), .i_wr_addr (i_wr_addr), .i_wr_data (i_wr_data),
      .o_wr_ready (o_wr_ready),
      .o_mem_en (o_mem_en), .o_mem_we (o_mem_we),
      .o_mem_addr (o_mem_addr), .o_mem_wdata (o_mem_wdata),
      .i_mem_rdata (i_mem_rdata),
      .i_clr_stat (i_clr_stat),
      .o_overflow (o_overflow), .o_drop_cnt (o_drop_cnt)
   );

   // RAM contents: a fixed pattern. Read addresses used never overlap writes.
   function automatic pixel_t pat(input logic [AW-1:0] a);
      return a[11:0] ^ 12'hAAC;
   endfunction

   // One-cycle-latency RAM.
   always @(posedge i_clk) begin
      if (o_mem_en === 1'b1 && o_mem_we === 1'b0) i_mem_rdata <= pat(o_mem_addr);
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- model ----------------
   typedef struct { int due; pixel_t data; } rd_t;
   typedef struct { logic [AW-1:0] a; pixel_t d; } wr_t;

   wr_t           q[$];
   rd_t           rdq[$];
   wr_t           w;
   rd_t           r;
   bit            full;
   bit            live = 0;
   int            cyc  = 0;
   logic          e_en, e_we, e_vld, e_ovf;
   logic [AW-1:0] e_addr;
   pixel_t        e_wdata, e_rdata;
   logic [15:0]   e_cnt;
   logic [AW-1:0] wr_log[$];
   int            rdv_cnt = 0;

   // At each falling edge: compare what the DUT shows now, then advance the
   // model with the inputs the next rising edge will sample.
   initial forever begin
      @(negedge i_clk);
      if (live) begin
         chk("mem_en",    o_mem_en,    e_en);
         chk("mem_we",    o_mem_we,    e_we);
         chk("mem_addr",  o_mem_addr,  e_addr);
         chk("mem_wdata", o_mem_wdata, e_wdata);
         chk("rd_valid",  o_rd_valid,  e_vld);
         chk("rd_data",   o_rd_data,   e_rdata);
         chk("overflow",  o_overflow,  e_ovf);
         chk("drop_cnt",  o_drop_cnt,  e_cnt);
         chk("wr_ready",  o_wr_ready,  (!i_rst && q.size() < DEPTH));
      end
      if (o_mem_en === 1'b1 && o_mem_we === 1'b1) wr_log.push_back(o_mem_addr);
      if (o_rd_valid === 1'b1) rdv_cnt++;

      if (i_rst) begin
         q.delete();
         rdq.delete();
         {e_en, e_we, e_vld, e_ovf} = '0;
         e_addr = '0; e_wdata = '0; e_rdata = '0; e_cnt = '0;
         live = 1;
      end else begin
         full = (q.size() == DEPTH);
         if (i_rd_req) begin
            e_en = 1; e_we = 0; e_addr = i_rd_addr;
            r.due = cyc + 2 + LAT; r.data = pat(i_rd_addr);
            rdq.push_back(r);
         end else if (q.size() > 0) begin
            w = q.pop_front();
            e_en = 1; e_we = 1; e_addr = w.a; e_wdata = w.d;
         end else begin
            e_en = 0; e_we = 0;
         end
         if (i_wr_valid && !full) begin
            w.a = i_wr_addr; w.d = i_wr_data;
            q.push_back(w);
         end else if (i_wr_valid && full) begin
            e_ovf = 1;
            if (i_clr_stat) e_cnt = 16'd1;
            else if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
         end
         if (i_clr_stat && !(i_wr_valid && full)) begin
            e_ovf = 0; e_cnt = '0;
         end
         e_vld = 0;
         if (rdq.size() > 0 && rdq[0].due == cyc + 1) begin
            e_vld = 1; e_rdata = rdq[0].data;
            void'(rdq.pop_front());
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   task automatic settle();
      @(negedge i_clk); #1;
   endtask

   initial begin
      i_rst = 1; i_rd_req = 1; i_rd_addr = 17'h55;
      i_wr_valid = 1; i_wr_addr = 17'h66; i_wr_data = 12'h077; i_clr_stat = 0;

      // Reset held for three edges while requests are driven.
      settle();
      chk("rst_wr_ready", o_wr_ready, 0);
      chk("rst_mem_en", o_mem_en, 0);
      repeat (2) tick();
      i_rst = 0; i_rd_req = 0; i_wr_valid = 0;
      settle();
      chk("post_rst_wr_ready", o_wr_ready, 1);
      chk("post_rst_mem_en", o_mem_en, 0);
      chk("post_rst_drop", o_drop_cnt, 0);

      // Read latency.
      tick(); i_rd_req = 1; i_rd_addr = 17'h00010;
      tick(); i_rd_req = 0;
      settle();
      chk("lat_mem_en", o_mem_en, 1);
      chk("lat_mem_addr", o_mem_addr, 17'h00010);
      tick(); tick();
      settle();
      chk("lat_rd_valid", o_rd_valid, 1);
      chk("lat_rd_data", o_rd_data, 12'hABC);
      tick(); settle();
      chk("lat_rd_valid_drop", o_rd_valid, 0);

      // Priority and drain.
      wr_log.delete();
      for (int i = 0; i < 20; i++) begin
         tick();
         i_rd_req = 1; i_rd_addr = AW'(17'h100 + i);
         i_wr_valid = (i < 5); i_wr_addr = AW'(17'h200 + i); i_wr_data = DW'(12'h300 + i);
      end
      tick(); i_rd_req = 0; i_wr_valid = 0;
      settle();
      chk("prio_no_wr_during_rd", wr_log.size(), 0);
      repeat (5) tick();
      settle();
      chk("prio_wr_count", wr_log.size(), 5);
      for (int k = 0; k < 5 && k < wr_log.size(); k++)
         chk("prio_wr_order", wr_log[k], 17'h200 + k);
      tick(); settle();
      chk("prio_wr_count_stable", wr_log.size(), 5);

      // Overflow: 20 writes behind 40 reads.
      wr_log.delete();
      for (int i = 0; i < 40; i++) begin
         tick();
         i_rd_req = 1; i_rd_addr = AW'(17'h140 + i);
         i_wr_valid = (i < 20); i_wr_addr = AW'(17'h400 + i); i_wr_data = DW'(12'h500 + i);
         if (i == 25) begin
            settle();
            chk("ovf_wr_ready", o_wr_ready, 0);
            chk("ovf_flag", o_overflow, 1);
            chk("ovf_cnt", o_drop_cnt, 4);
         end
      end
      tick(); i_rd_req = 0; i_wr_valid = 0;
      settle();
      chk("ovf_no_wr_during_rd", wr_log.size(), 0);
      repeat (16) tick();
      settle();
      chk("ovf_drain_count", wr_log.size(), 16);
      if (wr_log.size() == 16) begin
         chk("ovf_drain_first", wr_log[0], 17'h400);
         chk("ovf_drain_last", wr_log[15], 17'h40F);
      end
      tick(); settle();
      chk("ovf_ready_after_drain", o_wr_ready, 1);
      chk("ovf_cnt_holds", o_drop_cnt, 4);

      // Clear in the same cycle as a drop, then a plain clear.
      for (int i = 0; i < 18; i++) begin
         tick();
         i_rd_req = 1; i_rd_addr = AW'(17'h180 + i);
         i_wr_valid = (i < 17); i_wr_addr = AW'(17'h600 + i); i_wr_data = DW'(i);
         i_clr_stat = (i == 16);
      end
      settle();
      chk("clr_drop_flag", o_overflow, 1);
      chk("clr_drop_cnt", o_drop_cnt, 1);
      tick(); i_clr_stat = 1;
      tick(); i_clr_stat = 0;
      settle();
      chk("clr_only_flag", o_overflow, 0);
      chk("clr_only_cnt", o_drop_cnt, 0);
      tick(); i_rd_req = 0;
      repeat (18) tick();

      // Reset with 8 writes queued and reads in flight.
      for (int i = 0; i < 8; i++) begin
         tick();
         i_rd_req = 1; i_rd_addr = AW'(17'h1A0 + i);
         i_wr_valid = 1; i_wr_addr = AW'(17'h800 + i); i_wr_data = DW'(12'h080 + i);
      end
      tick(); i_rd_req = 0; i_wr_valid = 0; i_rst = 1;
      tick(); i_rst = 0; wr_log.delete(); rdv_cnt = 0;
      repeat (20) tick();
      settle();
      chk("midrst_no_writes", wr_log.size(), 0);
      chk("midrst_no_rd_valid", rdv_cnt, 0);
      chk("midrst_wr_ready", o_wr_ready, 1);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
